// File: rtl/tab_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : tab_pkg                                                    |
// | Shared types and constants for the table loader slice: FSM state     |
// | type, default table geometry and the number of lookup ports.         |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package tab_pkg;

   // Loader FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } tab_state_t;

   // Default table geometry
   localparam int DEF_NLOC   = 256;
   localparam int DEF_DBITS  = 32;

   // Number of consecutive entries presented on the lookup outputs
   localparam int NUM_LOOKUP = 4;

endpackage : tab_pkg
`default_nettype wire

// File: rtl/tab_table_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tab_table_ram                                              |
// | Table storage: one synchronous write port and NUM_LOOKUP             |
// | asynchronous read ports returning consecutive entries starting at    |
// | raddr, wrapping modulo Nloc. Contents are never reset.               |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tab_table_ram
   import tab_pkg::*;
#(
   parameter int Nloc  = DEF_NLOC,
   parameter int Dbits = DEF_DBITS
) (
   input  logic                                  clk,
   input  logic                                  we,
   input  logic [$clog2(Nloc)-1:0]               waddr,
   input  logic [Dbits-1:0]                      wdata,
   input  logic [$clog2(Nloc)-1:0]               raddr,
   output logic [NUM_LOOKUP-1:0][Dbits-1:0]      rdata
);

   localparam int AW = $clog2(Nloc);

   logic [Dbits-1:0] mem [Nloc];

   // Synchronous write; storage deliberately has no reset
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Asynchronous reads; Nloc is a power of two so the AW-bit sum wraps naturally
   generate
      for (genvar k = 0; k < NUM_LOOKUP; k++) begin : g_read
         logic [AW-1:0] idx;
         assign idx      = raddr + AW'(k);
         assign rdata[k] = mem[idx];
      end
   endgenerate

endmodule : tab_table_ram
`default_nettype wire

// File: rtl/tab_table_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tab_table_loader                                           |
// | Loads a full Nloc-entry table from a valid/ready word stream after a |
// | start pulse and offers four consecutive, wrap-around lookups.        |
// | Optional feature: define TAB_LOAD_CHECKSUM_EN to add an XOR checksum |
// | output over all words of the current load.                           |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tab_table_loader
   import tab_pkg::*;
#(
   parameter int Nloc  = DEF_NLOC,
   parameter int Dbits = DEF_DBITS
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     in_valid,
   input  logic [Dbits-1:0]         in_data,
   output logic                     in_ready,
   input  logic [$clog2(Nloc)-1:0]  readAddr,
   output logic [Dbits-1:0]         dataOut1,
   output logic [Dbits-1:0]         dataOut2,
   output logic [Dbits-1:0]         dataOut3,
   output logic [Dbits-1:0]         dataOut4,
   output logic                     loaded,
   output logic                     busy
`ifdef TAB_LOAD_CHECKSUM_EN
   ,
   output logic [Dbits-1:0]         checksum
`endif
);

   localparam int AW = $clog2(Nloc);

   tab_state_t                          state;
   logic [AW-1:0]                       ptr;
   logic                                xfer;
   logic [NUM_LOOKUP-1:0][Dbits-1:0]    rdata;

   // Handshake is a pure decode of the state register, never of in_valid
   assign in_ready = (state == LOAD);
   assign busy     = (state == LOAD);
   assign xfer     = in_ready && in_valid;

   // Load FSM: pointer advance, completion detection and loaded flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         ptr    <= '0;
         loaded <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state  <= LOAD;
                  ptr    <= '0;
                  loaded <= 1'b0;
               end
            end
            LOAD: begin
               if (in_valid) begin
                  ptr <= ptr + AW'(1);
                  if (ptr == AW'(Nloc - 1)) begin
                     state  <= DONE;
                     loaded <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef TAB_LOAD_CHECKSUM_EN
   // Running XOR of every accepted word, restarted by an accepted start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         checksum <= '0;
      end else if (start && (state != LOAD)) begin
         checksum <= '0;
      end else if (xfer) begin
         checksum <= checksum ^ in_data;
      end
   end
`endif

   tab_table_ram #(
      .Nloc  (Nloc),
      .Dbits (Dbits)
   ) u_ram (
      .clk   (clk),
      .we    (xfer),
      .waddr (ptr),
      .wdata (in_data),
      .raddr (readAddr),
      .rdata (rdata)
   );

   assign dataOut1 = rdata[0];
   assign dataOut2 = rdata[1];
   assign dataOut3 = rdata[2];
   assign dataOut4 = rdata[3];

endmodule : tab_table_loader
`default_nettype wire

// File: tb/tb_tab_table_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_tab_table_loader                                        |
// | Self-checking bench for tab_table_loader (Nloc=8, Dbits=32) with a   |
// | word-count reference model. Define TAB_LOAD_CHECKSUM_EN to include   |
// | the checksum scenarios.                                              |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_tab_table_loader;

   localparam int N  = 8;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic [2:0]    read_addr;
   logic [DW-1:0] d1, d2, d3, d4;
   logic          loaded;
   logic          busy;
`ifdef TAB_LOAD_CHECKSUM_EN
   logic [DW-1:0] checksum;
`endif

   wire [DW-1:0] dout [4];
   assign dout[0] = d1;
   assign dout[1] = d2;
   assign dout[2] = d3;
   assign dout[3] = d4;

   int checks = 0;
   int errors = 0;

   // Reference model: table contents, which entries are known, load progress
   logic [DW-1:0] m_mem   [N];
   bit            m_valid [N];
   bit            m_busy;
   bit            m_loaded;
   int            m_count;
   logic [DW-1:0] m_chk;

   tab_table_loader #(
      .Nloc  (N),
      .Dbits (DW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .readAddr (read_addr),
      .dataOut1 (d1),
      .dataOut2 (d2),
      .dataOut3 (d3),
      .dataOut4 (d4),
      .loaded   (loaded),
      .busy     (busy)
`ifdef TAB_LOAD_CHECKSUM_EN
      ,
      .checksum (checksum)
`endif
   );

   always #5 clk = ~clk;

   // Advance the model by one clock using the inputs currently driven, then clock the DUT
   task automatic step();
      if (m_busy) begin
         if (in_valid) begin
            m_mem[m_count]   = in_data;
            m_valid[m_count] = 1'b1;
            m_chk            = m_chk ^ in_data;
            m_count++;
            if (m_count == N) begin
               m_busy   = 1'b0;
               m_loaded = 1'b1;
            end
         end
      end else if (start) begin
         m_busy   = 1'b1;
         m_loaded = 1'b0;
         m_count  = 0;
         m_chk    = '0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_busy   = 1'b0;
      m_loaded = 1'b0;
      m_count  = 0;
      m_chk    = '0;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      start     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      read_addr = '0;
      for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      checks++;
      if (loaded !== 1'b0) begin errors++; $display("FAIL reset_loaded: got %b want 0", loaded); end
`ifdef TAB_LOAD_CHECKSUM_EN
      checks++;
      if (checksum !== '0) begin errors++; $display("FAIL reset_checksum: got %h want 0", checksum); end
`endif
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic_load();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < N; i++) begin
         in_valid = 1'b1;
         in_data  = 32'h10 + i;
         checks++;
         if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready word %0d: got %b want 1", i, in_ready); end
         step();
      end
      in_valid = 1'b0;
      checks++;
      if (loaded !== 1'b1) begin errors++; $display("FAIL basic_loaded: got %b want 1", loaded); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b want 0", busy); end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_after: got %b want 0", in_ready); end
      read_addr = 3'd0;
      #1;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (dout[k] !== 32'h10 + k) begin
            errors++;
            $display("FAIL basic_read dataOut%0d: got %h want %h", k + 1, dout[k], 32'h10 + k);
         end
      end
   endtask

   task automatic test_wrap();
      logic [DW-1:0] exp [4];
      exp[0] = 32'h16; exp[1] = 32'h17; exp[2] = 32'h10; exp[3] = 32'h11;
      read_addr = 3'd6;
      #1;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (dout[k] !== exp[k]) begin
            errors++;
            $display("FAIL wrap_read dataOut%0d: got %h want %h", k + 1, dout[k], exp[k]);
         end
      end
   endtask

   task automatic test_stall();
      int xfers = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 0; c < 2 * N; c++) begin
         in_valid = (c % 2 == 0);
         in_data  = 32'h50 + xfers;
         if (in_valid) xfers++;
         step();
         checks++;
         if (loaded !== (xfers == N)) begin
            errors++;
            $display("FAIL stall_loaded cycle %0d: got %b want %b", c, loaded, (xfers == N));
         end
      end
      in_valid = 1'b0;
      for (int a = 0; a < N; a += 4) begin
         read_addr = 3'(a);
         #1;
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (dout[k] !== 32'h50 + a + k) begin
               errors++;
               $display("FAIL stall_read addr %0d: got %h want %h", a + k, dout[k], 32'h50 + a + k);
            end
         end
      end
   endtask

   task automatic test_start_ignored();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < N; i++) begin
         in_valid = 1'b1;
         in_data  = 32'h30 + i;
         start    = (i == 2);
         step();
         checks++;
         if (loaded !== (i == N - 1)) begin
            errors++;
            $display("FAIL start_ign_loaded after word %0d: got %b want %b", i, loaded, (i == N - 1));
         end
      end
      start    = 1'b0;
      in_valid = 1'b0;
      for (int a = 0; a < N; a += 4) begin
         read_addr = 3'(a);
         #1;
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (dout[k] !== 32'h30 + a + k) begin
               errors++;
               $display("FAIL start_ign_read addr %0d: got %h want %h", a + k, dout[k], 32'h30 + a + k);
            end
         end
      end
   endtask

   task automatic test_reset_midload();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = 32'hE0 + i;
         step();
      end
      in_valid = 1'b0;
      #3 rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL midreset_in_ready: got %b want 0", in_ready); end
      checks++;
      if (loaded !== 1'b0) begin errors++; $display("FAIL midreset_loaded: got %b want 0", loaded); end
      // Partial contents survive reset
      read_addr = 3'd0;
      #1;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (dout[k] !== 32'hE0 + k) begin
            errors++;
            $display("FAIL midreset_keep addr %0d: got %h want %h", k, dout[k], 32'hE0 + k);
         end
      end
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < N; i++) begin
         in_valid = 1'b1;
         in_data  = 32'hA0 + i;
         step();
      end
      in_valid = 1'b0;
      checks++;
      if (loaded !== 1'b1) begin errors++; $display("FAIL midreset_reload_loaded: got %b want 1", loaded); end
      for (int a = 0; a < N; a += 4) begin
         read_addr = 3'(a);
         #1;
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (dout[k] !== 32'hA0 + a + k) begin
               errors++;
               $display("FAIL midreset_read addr %0d: got %h want %h", a + k, dout[k], 32'hA0 + a + k);
            end
         end
      end
      // Reset while loaded clears loaded immediately
      #3 rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (loaded !== 1'b0) begin errors++; $display("FAIL donereset_loaded: got %b want 0", loaded); end
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_random_loads();
      for (int l = 0; l < 4; l++) begin
         int cyc = 0;
         start = 1'b1;
         step();
         start = 1'b0;
         while (m_busy && cyc < 200) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            start     = ($urandom_range(0, 7) == 0);
            read_addr = 3'($urandom_range(0, N - 1));
            #1;
            checks++;
            if (in_ready !== m_busy) begin errors++; $display("FAIL rand_in_ready: got %b want %b", in_ready, m_busy); end
            for (int k = 0; k < 4; k++) begin
               int idx = (int'(read_addr) + k) % N;
               if (m_valid[idx]) begin
                  checks++;
                  if (dout[k] !== m_mem[idx]) begin
                     errors++;
                     $display("FAIL rand_read addr %0d: got %h want %h", idx, dout[k], m_mem[idx]);
                  end
               end
            end
            step();
            cyc++;
            checks++;
            if (loaded !== m_loaded) begin errors++; $display("FAIL rand_loaded: got %b want %b", loaded, m_loaded); end
`ifdef TAB_LOAD_CHECKSUM_EN
            checks++;
            if (checksum !== m_chk) begin errors++; $display("FAIL rand_checksum: got %h want %h", checksum, m_chk); end
`endif
         end
         start    = 1'b0;
         in_valid = 1'b0;
         checks++;
         if (m_busy) begin errors++; $display("FAIL rand_timeout: load %0d busy=%b after %0d cycles, want done", l, busy, cyc); end
      end
   endtask

`ifdef TAB_LOAD_CHECKSUM_EN
   task automatic test_checksum();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < N; i++) begin
         in_valid = 1'b1;
         in_data  = 32'h1 << i;
         step();
      end
      in_valid = 1'b0;
      checks++;
      if (loaded !== 1'b1) begin errors++; $display("FAIL chk_loaded: got %b want 1", loaded); end
      checks++;
      if (checksum !== 32'hFF) begin errors++; $display("FAIL chk_value: got %h want 000000ff", checksum); end
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (checksum !== 32'h0) begin errors++; $display("FAIL chk_clear: got %h want 0", checksum); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic_load();
      test_wrap();
      test_stall();
      test_start_ignored();
      test_reset_midload();
      test_random_loads();
`ifdef TAB_LOAD_CHECKSUM_EN
      test_checksum();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_tab_table_loader
`default_nettype wire

// File: doc/tab_table_loader.md
TAB_TABLE_LOADER -- requirements
Module: tab_table_loader

Interface
REQ-001 SHALL have parameter Nloc, default 256: number of table locations, power of two, at least 4.
REQ-002 SHALL have parameter Dbits, default 32: bits per table location.
REQ-003 SHALL have port clk, input, 1 bit: the only clock, rising-edge active.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: one-cycle pulse that requests a full table load.
REQ-006 SHALL have port in_valid, input, 1 bit: the load word on in_data is valid.
REQ-007 SHALL have port in_data, input, Dbits bits: the load word.
REQ-008 SHALL have port in_ready, output, 1 bit: the loader accepts a word this cycle.
REQ-009 SHALL have port readAddr, input, $clog2(Nloc) bits: base address for lookups.
REQ-010 SHALL have ports dataOut1, dataOut2, dataOut3 and dataOut4, each output, Dbits bits: four consecutive table entries.
REQ-011 SHALL have port loaded, output, 1 bit: the table holds a complete load.
REQ-012 SHALL have port busy, output, 1 bit: a load is in progress.

Function
REQ-013 SHALL implement an FSM with states IDLE, LOAD and DONE, held in a registered state variable.
REQ-014 In IDLE or DONE, start=1 at a rising edge SHALL move the FSM to LOAD, clear the write pointer to 0 and clear loaded, all at that same edge.
REQ-015 In LOAD, start SHALL be ignored.
REQ-016 in_ready and busy SHALL be 1 exactly when the state is LOAD; both are decoded from the state register with no combinational path from in_valid.
REQ-017 A transfer SHALL occur at a rising edge where in_valid=1 and in_ready=1.
REQ-018 On a transfer, the block SHALL write in_data to mem[ptr] and increment ptr.
REQ-019 On the transfer with ptr=Nloc-1, the FSM SHALL move to DONE and set loaded=1 at that edge, so in_ready=0 on the following cycle.
REQ-020 in_valid=0 cycles during LOAD SHALL stall the load without losing state; there is no timeout.
REQ-021 A full load SHALL take exactly Nloc transfers; the minimum is Nloc cycles after the start edge.
REQ-022 dataOutk SHALL equal mem[(readAddr+k-1) mod Nloc] combinationally, with no clock in the read path.
REQ-023 The read index SHALL wrap modulo Nloc; for example, readAddr=Nloc-1 gives dataOut2=mem[0].
REQ-024 Reads SHALL be permitted in every state; a location written at edge n SHALL be visible on dataOut from edge n onward.
REQ-025 loaded SHALL stay 1 in DONE until the next accepted start.

Reset
REQ-026 rst_n=0 SHALL force, asynchronously: state=IDLE, ptr=0, in_ready=0, busy=0, loaded=0, and checksum=0 when compiled in.
REQ-027 Table memory SHALL NOT be reset; a reset in the middle of a load leaves partial contents in memory and loaded=0.
REQ-028 Operation SHALL resume at the first rising edge after rst_n deasserts.

Configuration
REQ-029 With macro TAB_LOAD_CHECKSUM_EN defined, the block SHALL add output checksum, Dbits bits: a register cleared on an accepted start and XORed with in_data on every transfer, final once loaded=1.
REQ-030 Without TAB_LOAD_CHECKSUM_EN, the checksum port and its register SHALL be absent, and all other behaviour is identical.

Structure
REQ-031 Package tab_pkg SHALL hold the state enum type (IDLE/LOAD/DONE), the default Nloc and Dbits constants, and the number of lookup ports (4).
REQ-032 Sub-module tab_table_ram SHALL hold the storage: one synchronous write port and four asynchronous wrap-around read ports.
REQ-033 tab_table_loader SHALL hold the FSM, the pointer, the handshake logic and the optional checksum.

Verification (Nloc=8, Dbits=32)
REQ-034 Reset, then start, then 8 back-to-back words 0x10..0x17: expect in_ready high for 8 cycles, loaded=1 and busy=0 after the 8th edge, and readAddr=0 gives dataOut1..4=0x10,0x11,0x12,0x13.
REQ-035 Wrap check after the REQ-034 load: readAddr=6 gives dataOut1..4=0x16,0x17,0x10,0x11.
REQ-036 Load with in_valid toggling 1,0,1,0...: expect exactly 8 words stored in order, loaded set only after the 8th transfer, and no skipped or duplicated addresses.
REQ-037 start pulsed at the 3rd transfer of a load: expect it ignored, the load completing after 8 transfers, and ptr not restarted.
REQ-038 rst_n asserted after 5 transfers, then released: expect loaded=0 and in_ready=0 immediately, then start and 8 words 0xA0..0xA7 read back correctly.
REQ-039 With TAB_LOAD_CHECKSUM_EN, words 0x1,0x2,0x4,0x8,0x10,0x20,0x40,0x80: expect checksum=0xFF at loaded=1, and checksum=0 one cycle after the next start.
